// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: ISA opcodes seen by fetch, fetch state encodings, bubble word.
// Optional perf counters in fetch_stage are enabled with FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_NOP = 4'h0;

  localparam logic [15:0] BUBBLE = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_DRAIN  = 2'd1,
    FS_HALTED = 2'd2
  } fetchState_t;

  // True for words that end straight-line fetch (resolved later in the pipe).
  function automatic logic isFlowChange(input logic [15:0] instr);
    return (instr[15:12] == OP_HLT) || (instr[15:12] == OP_B) ||
           (instr[15:12] == OP_JAL) || (instr[15:12] == OP_JR);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry skid buffer holding one fetched word and its pc+1 while decode is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [15:0] instrIn,
  input  logic [15:0] pcPlus1In,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pcPlus1
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid   <= 1'b0;
      instr   <= 16'h0000;
      pcPlus1 <= 16'h0000;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instrIn;
      pcPlus1 <= pcPlus1In;
    end else if (unload) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with single-outstanding imem handshake and a skid entry.
// Define FETCH_PERF_CNT_EN to add the fetchCnt/bubbleCnt performance counters.
//
// state     | meaning
// FS_FETCH  | requesting imem at pc, loading IF/ID (or skid when stalled)
// FS_DRAIN  | squashed request still outstanding; wait for imemRdy and drop the data
// FS_HALTED | HLT reached decode; no requests until redirect or rst
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = BUBBLE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imemAddr,
  output logic        imemRdEn,
  input  logic        imemRdy,
  input  logic [15:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  input  logic        hltSeen,
  output logic [15:0] instrOut,
  output logic [15:0] pcPlus1Out,
  output logic        instrValid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] fetchCnt,
  output logic [15:0] bubbleCnt,
`endif
  output logic        halted
);

  fetchState_t state;
  logic [15:0] pc;
  logic [15:0] pcNext;
  logic        skidValid, skidLoad, skidUnload, skidClear, loadFromMem;
  logic [15:0] skidInstr, skidPcPlus1;

  assign pcNext = pc + 16'd1;

  always_comb begin
    skidLoad    = 1'b0;
    skidUnload  = 1'b0;
    skidClear   = redirect || hltSeen;
    loadFromMem = 1'b0;
    if (!skidClear && state == FS_FETCH) begin
      if (stall)
        skidLoad = imemRdEn && imemRdy && !skidValid;
      else if (skidValid)
        skidUnload = 1'b1;
      else
        loadFromMem = imemRdEn && imemRdy;
    end
  end

  fetch_skid uSkid (
    .clk       (clk),
    .rst       (rst),
    .load      (skidLoad),
    .unload    (skidUnload),
    .clear     (skidClear),
    .instrIn   (imemData),
    .pcPlus1In (pcNext),
    .valid     (skidValid),
    .instr     (skidInstr),
    .pcPlus1   (skidPcPlus1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FS_FETCH;
      pc         <= RESET_PC;
      imemAddr   <= RESET_PC;
      imemRdEn   <= 1'b0;
      instrOut   <= BUBBLE_INSTR;
      pcPlus1Out <= 16'h0000;
      instrValid <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect) begin
      pc         <= redirectPc;
      instrValid <= 1'b0;
      instrOut   <= BUBBLE_INSTR;
      halted     <= 1'b0;
      imemRdEn   <= 1'b1;
      // An unanswered request keeps its old address until memory responds.
      if (imemRdEn && !imemRdy) begin
        state <= FS_DRAIN;
      end else begin
        state    <= FS_FETCH;
        imemAddr <= redirectPc;
      end
    end else if (hltSeen) begin
      state      <= FS_HALTED;
      halted     <= 1'b1;
      imemRdEn   <= 1'b0;
      instrValid <= 1'b0;
      instrOut   <= BUBBLE_INSTR;
    end else begin
      case (state)
        FS_FETCH: begin
          if (stall) begin
            if (skidLoad) begin
              pc       <= pcNext;
              imemRdEn <= 1'b0;
            end else if (!skidValid) begin
              imemRdEn <= 1'b1;
              imemAddr <= pc;
            end else begin
              imemRdEn <= 1'b0;
            end
          end else if (skidValid) begin
            instrOut   <= skidInstr;
            pcPlus1Out <= skidPcPlus1;
            instrValid <= 1'b1;
            imemRdEn   <= 1'b1;
            imemAddr   <= pc;
          end else if (loadFromMem) begin
            instrOut   <= imemData;
            pcPlus1Out <= pcNext;
            instrValid <= 1'b1;
            pc         <= pcNext;
            imemRdEn   <= 1'b1;
            imemAddr   <= pcNext;
          end else begin
            instrValid <= 1'b0;
            instrOut   <= BUBBLE_INSTR;
            imemRdEn   <= 1'b1;
            imemAddr   <= pc;
          end
        end
        FS_DRAIN: begin
          if (imemRdy) begin
            state    <= FS_FETCH;
            imemRdEn <= 1'b1;
            imemAddr <= pc;
          end
        end
        FS_HALTED: begin
          imemRdEn <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= FS_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt  <= 16'h0000;
      bubbleCnt <= 16'h0000;
    end else begin
      if ((loadFromMem || skidUnload) && fetchCnt != 16'hFFFF)
        fetchCnt <= fetchCnt + 16'd1;
      if (!instrValid && state != FS_HALTED && bubbleCnt != 16'hFFFF)
        bubbleCnt <= bubbleCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr+16'h1000, with optional manual rdy control.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imemAddr;
  logic        imemRdEn;
  logic        imemRdy;
  logic [15:0] imemData;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        hltSeen;
  logic [15:0] instrOut;
  logic [15:0] pcPlus1Out;
  logic        instrValid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetchCnt;
  logic [15:0] bubbleCnt;
`endif

  logic autoRdy;
  logic manRdy;
  int   nVec = 0;
  int   nMis = 0;

  always #5 clk = ~clk;

  always_comb begin
    imemRdy  = autoRdy ? imemRdEn : manRdy;
    imemData = imemAddr + 16'h1000;
  end

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imemAddr   (imemAddr),
    .imemRdEn   (imemRdEn),
    .imemRdy    (imemRdy),
    .imemData   (imemData),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .hltSeen    (hltSeen),
    .instrOut   (instrOut),
    .pcPlus1Out (pcPlus1Out),
    .instrValid (instrValid),
`ifdef FETCH_PERF_CNT_EN
    .fetchCnt   (fetchCnt),
    .bubbleCnt  (bubbleCnt),
`endif
    .halted     (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [15:0] ins, input logic [15:0] pcp);
    check({tag, "_instr"}, instrOut, ins);
    check({tag, "_pcp1"}, pcPlus1Out, pcp);
    check({tag, "_valid"}, {15'd0, instrValid}, 16'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0000;
    hltSeen = 1'b0; autoRdy = 1'b1; manRdy = 1'b0;
    tick(); tick();
    check("rst_rdEn",   {15'd0, imemRdEn},   16'd0);
    check("rst_valid",  {15'd0, instrValid}, 16'd0);
    check("rst_instr",  instrOut,            16'h0000);
    check("rst_pcp1",   pcPlus1Out,          16'h0000);
    check("rst_halted", {15'd0, halted},     16'd0);

    rst = 1'b0;
    tick();
    check("first_rdEn", {15'd0, imemRdEn}, 16'd1);
    check("first_addr", imemAddr,          16'h0000);
    tick(); checkIfId("seq0", 16'h1000, 16'h0001);
    tick(); checkIfId("seq1", 16'h1001, 16'h0002);
    tick(); checkIfId("seq2", 16'h1002, 16'h0003);
    tick(); checkIfId("seq3", 16'h1003, 16'h0004);
    check("seq3_addr", imemAddr, 16'h0004);

    // memory wait states on address 0004
    autoRdy = 1'b0; manRdy = 1'b0;
    tick();
    check("wait1_valid", {15'd0, instrValid}, 16'd0);
    check("wait1_addr",  imemAddr,            16'h0004);
    check("wait1_rdEn",  {15'd0, imemRdEn},   16'd1);
    tick();
    check("wait2_valid", {15'd0, instrValid}, 16'd0);
    check("wait2_addr",  imemAddr,            16'h0004);
    autoRdy = 1'b1;
    tick(); checkIfId("waitdone", 16'h1004, 16'h0005);
    check("waitdone_addr", imemAddr, 16'h0005);

    // stall while 1005 returns into the skid
    stall = 1'b1;
    tick();
    check("stall1_rdEn", {15'd0, imemRdEn}, 16'd0);
    checkIfId("stall1", 16'h1004, 16'h0005);
    tick(); tick();
    check("stall3_rdEn", {15'd0, imemRdEn}, 16'd0);
    checkIfId("stall3", 16'h1004, 16'h0005);
    stall = 1'b0;
    tick(); checkIfId("skidout", 16'h1005, 16'h0006);
    check("skidout_rdEn", {15'd0, imemRdEn}, 16'd1);
    check("skidout_addr", imemAddr,          16'h0006);
    tick(); checkIfId("resume", 16'h1006, 16'h0007);

    // redirect while request for 0007 is unanswered -> drain
    autoRdy = 1'b0; manRdy = 1'b0; redirect = 1'b1; redirectPc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("drain1_valid", {15'd0, instrValid}, 16'd0);
    check("drain1_instr", instrOut,            16'h0000);
    check("drain1_addr",  imemAddr,            16'h0007);
    check("drain1_rdEn",  {15'd0, imemRdEn},   16'd1);
    tick();
    check("drain2_addr", imemAddr, 16'h0007);
    manRdy = 1'b1;
    tick();
    manRdy = 1'b0; autoRdy = 1'b1;
    check("drained_valid", {15'd0, instrValid}, 16'd0);
    check("drained_addr",  imemAddr,            16'h0040);
    tick(); checkIfId("redir", 16'h1040, 16'h0041);

    // redirect coincident with rdy: data dropped, no drain
    redirect = 1'b1; redirectPc = 16'h000F;
    tick();
    redirect = 1'b0;
    check("redirRdy_valid", {15'd0, instrValid}, 16'd0);
    check("redirRdy_addr",  imemAddr,            16'h000F);
    tick(); checkIfId("pre_hlt", 16'h100F, 16'h0010);

    // halt at pc 0010
    hltSeen = 1'b1;
    tick();
    hltSeen = 1'b0;
    check("hlt_halted", {15'd0, halted},     16'd1);
    check("hlt_rdEn",   {15'd0, imemRdEn},   16'd0);
    check("hlt_valid",  {15'd0, instrValid}, 16'd0);
    repeat (4) tick();
    check("hlt_hold_halted", {15'd0, halted},   16'd1);
    check("hlt_hold_rdEn",   {15'd0, imemRdEn}, 16'd0);
    redirect = 1'b1; redirectPc = 16'h0020;
    tick();
    redirect = 1'b0;
    check("unhalt_halted", {15'd0, halted},   16'd0);
    check("unhalt_rdEn",   {15'd0, imemRdEn}, 16'd1);
    check("unhalt_addr",   imemAddr,          16'h0020);
    tick(); checkIfId("unhalt", 16'h1020, 16'h0021);

    // pc wrap at FFFF
    redirect = 1'b1; redirectPc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imemAddr, 16'hFFFF);
    tick(); checkIfId("wrap", 16'h0FFF, 16'h0000);
    check("wrap_next_addr", imemAddr, 16'h0000);
    tick(); checkIfId("wrap_next", 16'h1000, 16'h0001);

    // reset with a request in flight
    rst = 1'b1;
    tick();
    check("midrst_rdEn",  {15'd0, imemRdEn},   16'd0);
    check("midrst_valid", {15'd0, instrValid}, 16'd0);
    check("midrst_pcp1",  pcPlus1Out,          16'h0000);
    rst = 1'b0;
    tick();
    check("postrst_addr", imemAddr,          16'h0000);
    check("postrst_rdEn", {15'd0, imemRdEn}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core.
- Holds the PC and issues single-outstanding reads to instruction memory over a rdEn/rdy handshake.
- Buffers one returned word in a skid entry while the pipeline is stalled.
- Presents instr/pcPlus1/instrValid to the decode stage, whose control decoder drives hltSeen back; executes redirects from branch/jump resolution.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
BUBBLE_INSTR, 16'h0000, instruction word driven on instrOut when instrValid=0

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
imemAddr  output  16  fetch address (word-addressed)
imemRdEn  output  1  read request; held with imemAddr until imemRdy
imemRdy  input  1  imemData valid this cycle; may assert the same cycle as imemRdEn
imemData  input  16  instruction word
stall  input  1  hold IF/ID register (hazard unit)
redirect  input  1  branch taken / jump resolved
redirectPc  input  16  redirect target
hltSeen  input  1  decode stage holds a valid HLT
instrOut  output  16  IF/ID instruction
pcPlus1Out  output  16  IF/ID PC+1, used for JAL link and branch base
instrValid  output  1  IF/ID entry valid
halted  output  1  fetch stopped on HLT

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, instrValid=0, instrOut=BUBBLE_INSTR, pcPlus1Out=0, skid empty, halted=0, imemRdEn=0. The first request is issued the cycle after rst deasserts.
- States:
  - FETCH: imemRdEn=1, imemAddr=pc.
  - DRAIN: a squashed request is outstanding; imemRdEn stays 1 at the old address until imemRdy, then the response is discarded.
  - HALTED: imemRdEn=0, halted=1.
- Priority each cycle: rst > redirect > hltSeen > stall > normal.
- Normal, FETCH with imemRdy=1 and stall=0:
  - Next cycle: instrOut=imemData, pcPlus1Out=pc+1 (mod 2^16, wraps FFFF->0000), instrValid=1, pc<=pc+1.
  - Throughput is 1 instr/cycle with zero-wait memory.
- FETCH with imemRdy=0: instrValid<=0 (bubble); request and address held.
- Stall=1: the IF/ID register holds all fields.
  - If imemRdy arrives with the skid empty, the word and its pc+1 go to the skid, pc advances, and imemRdEn drops until the skid drains.
  - On stall release, the skid loads into IF/ID; fetch resumes the next cycle.
  - Skid full with stall=1: no request is issued.
- Redirect:
  - pc<=redirectPc; IF/ID is flushed (instrValid=0, instrOut=BUBBLE_INSTR); skid is cleared.
  - If a request is in flight with imemRdy=0, go to DRAIN; otherwise go to FETCH at redirectPc the next cycle.
  - Redirect overrides stall, and overrides HALTED (HLT was wrong-path).
- hltSeen=1 (no redirect): go to HALTED; IF/ID is cleared to a bubble. An in-flight response is discarded: HALTED accepts imemRdy and ignores it.
- Exiting HALTED: only rst or redirect.
- Simultaneous redirect and imemRdy in FETCH: the data is dropped; the next state is FETCH at redirectPc (no DRAIN).
- Reset mid-request: the request is abandoned; the memory model must tolerate the dropped rdEn.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined, add outputs fetchCnt[15:0] and bubbleCnt[15:0]:
  - fetchCnt counts cycles where IF/ID loads a valid instruction.
  - bubbleCnt counts cycles where instrValid=0 and state≠HALTED.
  - Both saturate at FFFF and reset to 0.
- Without the macro, the ports and logic are absent.

Decomposition:
- Shared defines file (existing defines.v): ISA opcode constants (HLT, B, JAL, JR), the fetch state encodings FS_FETCH/FS_DRAIN/FS_HALTED, and the bubble encoding.
- One sub-module, fetch_skid: a single-entry skid buffer (instr + pcPlus1, valid flag, load/unload/clear).

Test Plan:
- Reset, then a zero-wait memory returning addr+16'h1000 -> instrOut 1000, 1001, 1002 on consecutive cycles; pcPlus1Out 0001, 0002, 0003.
- imemRdy delayed 2 cycles on addr 0004 -> two bubbles (instrValid=0), imemAddr held at 0004, then instrOut=1004.
- stall held 3 cycles while imemRdy returns 1005 -> IF/ID unchanged; skid holds 1005; imemRdEn=0; after release instrOut=1005, then 1006.
- redirect to 0040 while the request for 0007 waits 2 cycles -> DRAIN; the 0007 data is discarded; next valid instrOut=1040 with pcPlus1Out=0041.
- hltSeen at pc 0010 -> halted=1, imemRdEn=0 indefinitely; a later redirect to 0020 resumes with instrOut=1020.
- PC at FFFF -> pcPlus1Out=0000, next fetch address 0000.
